padder: RTL
===========

# padder

Sequential message padder for the high-throughput Keccak core. It accepts the message as 64-bit words, pads the final word through the existing combinational `padder1` (first pad byte 0x01), and zero-fills the remaining words. It sets the final pad bit (0x80 in the last byte of the last word) and presents complete 576-bit rate blocks to the permutation stage through a full/ack handshake.

## Interface
- `RATE_WORDS`, default 9: 64-bit words per rate block (576 bits).
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in`  in  64: message word; byte 0 is `in[63:56]`.
- `in_ready`  in  1: `in` holds a valid word this cycle.
- `is_last`  in  1: qualifies `in` as the final (possibly partial) word of the message.
- `byte_num`  in  3: valid bytes in the final word (0–7); used only when `is_last`=1.
- `accept`  out  1: combinational; word on `in` is consumed at this edge.
- `buffer_full`  out  1: `out` holds a complete block.
- `out`  out  64*RATE_WORDS: block; first word accepted ends in the top 64 bits.
- `f_ack`  in  1: consumer has taken the block; frees the buffer.

## Operation
- Reset (`reset_n`=0 at edge): `out`=0, word count=0, `buffer_full`=0, state=ST_DATA.
- States: ST_DATA (taking message words), ST_PAD (inserting pad words), ST_DONE (final block held, message complete).
- `accept` = `in_ready` & ~`buffer_full` & (state==ST_DATA).
- On accept: `out` <= {`out`[575-64:0], w} and count+1.
  - w = `in` when `is_last`=0.
  - w = `padder1(in, byte_num)` when `is_last`=1; state then goes to ST_PAD.
- ST_PAD with ~`buffer_full`: shift in 64'h0 each cycle and count+1.
- Final-bit rule: the word entering slot RATE_WORDS-1 (count==RATE_WORDS-1) after `is_last` has been taken is ORed with 64'h80. This covers the word carrying `is_last` itself.
  - Example: `byte_num`=7 in the last slot gives low byte 0x81.
- When the block that received the final-bit word fills, state goes to ST_DONE.
- `buffer_full` = (count==RATE_WORDS), registered.
- `f_ack` while `buffer_full`: count <= 0 and `buffer_full` <= 0.
  - If state==ST_DONE, state <= ST_DATA (next message).
  - `out` is not cleared; it is overwritten by the shifts that follow.
- `f_ack` while ~`buffer_full`: ignored.
- Message ending exactly on a block boundary (`is_last` with `byte_num`=0 in slot 0 of a new block): produces a full pad block, 0x01 at the top byte and 0x80 at the bottom.
- `in_ready` in ST_PAD, ST_DONE or while full: not accepted; upstream holds the word.
- `is_last`/`byte_num` ignored unless `accept`=1.

## Timing
- One word per cycle in ST_DATA and ST_PAD; no bubbles while not full.
- `buffer_full` rises the cycle after the edge that writes the RATE_WORDS-th word.
- Example: empty message accepted at edge 0 gives `buffer_full`=1 after edge 8 (8 pad cycles).
- `f_ack` and `in_ready` in the same full cycle: the ack clears the buffer at that edge; the word is taken no earlier than the next cycle.
- Earliest restart: the cycle after the `f_ack` edge.
- `out` is stable the entire time `buffer_full`=1.
- Reset mid-block or mid-pad: all state clears at that edge; the partial block is discarded.

## Structure
- Shared package `keccak_pkg`:
  - `WORD_W`=64 and `RATE_WORDS`=9.
  - `PAD_FIRST`=8'h01 and `PAD_LAST`=64'h80.
  - State enum {ST_DATA, ST_PAD, ST_DONE}.
- One sub-module: the existing `padder1`, instantiated unmodified for the last-word mux.
- Counter width is $clog2(RATE_WORDS+1).

## Test plan
- Empty message: `is_last`=1, `byte_num`=0 at first accept -> after 9 edges `buffer_full`=1 and `out`={64'h0100000000000000, 448'h0, 64'h80}.
- 3-word message, last word 64'h1234567890ABCDEF with `byte_num`=3:
  - `out`={w0, w1, 64'h1234560100000000, 320'h0, 64'h80}.
  - `accept` low during the 6 pad cycles.
- `is_last` in slot 8 with `byte_num`=7, `in`=64'h1234567890ABCDEF -> low word 64'h1234567890ABCD81; ST_DONE with no extra block.
- Exactly 9 full words, then `is_last` with `byte_num`=0:
  - First block has no pad bits.
  - After `f_ack`, the second block is the pad-only block.
- Backpressure: hold `in_ready`=1 while full for 5 cycles -> `accept`=0 and `out` unchanged; `f_ack` same cycle as `in_ready` -> word taken the next cycle.
- `reset_n`=0 during ST_PAD -> next cycle `out`=0, `buffer_full`=0; a new message is accepted cleanly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak message padder.
package keccak_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned RATE_WORDS = 9;

  localparam logic [7:0]        PAD_FIRST = 8'h01;
  localparam logic [WORD_W-1:0] PAD_LAST  = 64'h80;

  typedef enum logic [1:0] {
    ST_DATA,
    ST_PAD,
    ST_DONE
  } padder_state_e;

endpackage

// File: rtl/padder1.sv
// Combinational last-word padder: keeps the first byte_num bytes of the word,
// places the first pad byte right after them and zeroes the rest.
module padder1
  import keccak_pkg::*;
(
  input  logic [63:0] in,
  input  logic [2:0]  byte_num,
  output logic [63:0] out
);

  // Byte b (b = 0 is in[63:56]) is kept, replaced by the pad byte, or zeroed.
  always_comb begin
    out = '0;
    for (int b = 0; b < 8; b++) begin
      if (3'(b) < byte_num) begin
        out[63-8*b -: 8] = in[63-8*b -: 8];
      end else if (3'(b) == byte_num) begin
        out[63-8*b -: 8] = PAD_FIRST;
      end
    end
  end

endmodule

// File: rtl/padder.sv
// Sequential message padder: shifts 64-bit message words into a rate block,
// pads the final word, zero-fills the block, sets the final pad bit and hands
// complete blocks to the permutation through a full/ack handshake.
module padder
  import keccak_pkg::WORD_W;
  import keccak_pkg::PAD_LAST;
  import keccak_pkg::padder_state_e;
  import keccak_pkg::ST_DATA;
  import keccak_pkg::ST_PAD;
  import keccak_pkg::ST_DONE;
#(
  parameter int unsigned RATE_WORDS = keccak_pkg::RATE_WORDS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [WORD_W-1:0]            in,
  input  logic                         in_ready,
  input  logic                         is_last,
  input  logic [2:0]                   byte_num,
  output logic                         accept,
  output logic                         buffer_full,
  output logic [WORD_W*RATE_WORDS-1:0] out,
  input  logic                         f_ack
);

  localparam int unsigned OutW = WORD_W * RATE_WORDS;
  localparam int unsigned CntW = $clog2(RATE_WORDS + 1);

  localparam logic [CntW-1:0] LastSlot = CntW'(RATE_WORDS - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(RATE_WORDS);

  padder_state_e     state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic [OutW-1:0]   out_q, out_d;

  logic [WORD_W-1:0] pad_word;
  logic [WORD_W-1:0] word;
  logic              shift;

  padder1 u_padder1 (
    .in       (in),
    .byte_num (byte_num),
    .out      (pad_word)
  );

  assign accept      = in_ready & ~full_q & (state_q == ST_DATA);
  assign buffer_full = full_q;
  assign out         = out_q;

  // Next-state: ack handling while full, otherwise shift in a data or pad word.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    out_d   = out_q;
    shift   = 1'b0;
    word    = '0;

    if (full_q) begin
      // out_q is left as is; subsequent shifts overwrite it.
      if (f_ack) begin
        count_d = '0;
        full_d  = 1'b0;
        if (state_q == ST_DONE) begin
          state_d = ST_DATA;
        end
      end
    end else begin
      case (state_q)
        ST_DATA: begin
          if (in_ready) begin
            shift = 1'b1;
            if (is_last) begin
              word    = pad_word;
              state_d = ST_PAD;
            end else begin
              word = in;
            end
          end
        end
        ST_PAD: begin
          shift = 1'b1;
        end
        default: ;
      endcase

      if (shift) begin
        // The word landing in the last slot once the message has ended carries
        // the final pad bit, and that block closes the message.
        if ((count_q == LastSlot) && (state_d == ST_PAD)) begin
          word    = word | PAD_LAST;
          state_d = ST_DONE;
        end
        out_d   = {out_q[OutW-WORD_W-1:0], word};
        count_d = count_q + CntW'(1);
        full_d  = (count_d == FullCnt);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_DATA;
      count_q <= '0;
      full_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      out_q   <= out_d;
    end
  end

endmodule
